// File: rtl/cb_conflict_gate.sv
// rtl/cb_conflict_gate.sv - request gate that stalls requests aliasing in-flight lines via cb_filter
//
// Purpose: admits upstream requests only when the counting filter reports no possible
//   conflict, records issued line addresses in an in-order FIFO (incr), and retires
//   them on in-order responses (decr). A flush drains traffic and clears the filter.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       level request: drain, then pulse filter_clear_o
//   req_valid_i/req_ready_o/req_addr_i   upstream request channel
//   req_valid_o/req_ready_i/req_addr_o   downstream request channel
//   rsp_valid_i                   in-order response for the oldest in-flight request
//   look_data_o/look_valid_i      filter lookup of the current request line
//   incr_data_o/incr_valid_o      filter insert on issue
//   decr_data_o/decr_valid_o      filter remove on response (FIFO head)
//   filter_clear_o                one-cycle filter clear after a flush drains
//   filter_full_i/filter_error_i  filter status flags
//   outstanding_o, stall_cnt_o, error_o   status
module cb_conflict_gate #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned LineOffset = 6,
  parameter int unsigned MaxOutst   = 8,
  parameter int unsigned StallCntW  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [AddrWidth-1:0]            req_addr_i,
  output logic                            req_valid_o,
  input  logic                            req_ready_i,
  output logic [AddrWidth-1:0]            req_addr_o,
  input  logic                            rsp_valid_i,
  output logic [AddrWidth-LineOffset-1:0] look_data_o,
  input  logic                            look_valid_i,
  output logic [AddrWidth-LineOffset-1:0] incr_data_o,
  output logic                            incr_valid_o,
  output logic [AddrWidth-LineOffset-1:0] decr_data_o,
  output logic                            decr_valid_o,
  output logic                            filter_clear_o,
  input  logic                            filter_full_i,
  input  logic                            filter_error_i,
  output logic [$clog2(MaxOutst+1)-1:0]   outstanding_o,
  output logic [StallCntW-1:0]            stall_cnt_o,
  output logic                            error_o
);

  localparam int unsigned LineW = AddrWidth - LineOffset;
  localparam int unsigned PtrW  = $clog2(MaxOutst);
  localparam int unsigned CntW  = $clog2(MaxOutst + 1);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_e;

  state_e                 state_q;
  logic                   clear_q;
  logic [LineW-1:0]       fifo_q [MaxOutst];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [StallCntW-1:0]   stall_q, stall_d;
  logic                   err_q, err_d;

  logic is_run, rsp_hit, room, issue_ok, issue;

  assign look_data_o = req_addr_i[AddrWidth-1:LineOffset];
  assign req_addr_o  = req_addr_i;

  assign is_run  = (state_q == RUN);
  assign rsp_hit = rsp_valid_i & (cnt_q != '0);
  // A retiring response frees a slot in the same cycle, so a full gate may still issue.
  assign room     = (cnt_q != CntW'(MaxOutst)) | rsp_hit;
  assign issue_ok = is_run & ~look_valid_i & ~filter_full_i & room;

  assign req_valid_o = req_valid_i & issue_ok;
  assign req_ready_o = req_ready_i & issue_ok;
  assign issue       = req_valid_o & req_ready_i;

  assign incr_valid_o   = issue;
  assign incr_data_o    = look_data_o;
  assign decr_valid_o   = rsp_hit;
  assign decr_data_o    = fifo_q[rd_ptr_q];
  assign filter_clear_o = clear_q;
  assign outstanding_o  = cnt_q;
  assign stall_cnt_o    = stall_q;
  assign error_o        = err_q;

  always_comb begin
    wr_ptr_d = issue   ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rsp_hit ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (issue && !rsp_hit) cnt_d = cnt_q + CntW'(1);
    else if (!issue && rsp_hit) cnt_d = cnt_q - CntW'(1);
    stall_d = stall_q;
    if (req_valid_i && is_run && look_valid_i && !(&stall_q)) stall_d = stall_q + StallCntW'(1);
    err_d = err_q | filter_error_i | (rsp_valid_i & (cnt_q == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // Line storage needs no reset: entries are only read while counted as in flight.
  always_ff @(posedge clk_i) begin
    if (issue) fifo_q[wr_ptr_q] <= look_data_o;
  end

  // Flush sequencing; clear_q is raised on entry to CLEAR so it lasts exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      clear_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        RUN:     if (flush_i) state_q <= DRAIN;
        DRAIN:   if (cnt_q == '0) begin
                   state_q <= CLEAR;
                   clear_q <= 1'b1;
                 end
        CLEAR:   state_q <= flush_i ? DRAIN : RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_conflict_gate.sv
// tb/tb_cb_conflict_gate.sv - randomized and directed bench for cb_conflict_gate against a queue model
module tb_cb_conflict_gate;

  localparam int AW = 32;
  localparam int LO = 6;
  localparam int MO = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_ni;
  logic flush_i, req_valid_i, req_ready_i, rsp_valid_i;
  logic look_valid_i, filter_full_i, filter_error_i;
  logic [AW-1:0] req_addr_i;
  logic req_ready_o, req_valid_o, incr_valid_o, decr_valid_o, filter_clear_o, error_o;
  logic [AW-1:0] req_addr_o;
  logic [AW-LO-1:0] look_data_o, incr_data_o, decr_data_o;
  logic [$clog2(MO+1)-1:0] outstanding_o;
  logic [SW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  cb_conflict_gate #(.AddrWidth(AW), .LineOffset(LO), .MaxOutst(MO), .StallCntW(SW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i),
    .look_data_o(look_data_o), .look_valid_i(look_valid_i),
    .incr_data_o(incr_data_o), .incr_valid_o(incr_valid_o),
    .decr_data_o(decr_data_o), .decr_valid_o(decr_valid_o),
    .filter_clear_o(filter_clear_o), .filter_full_i(filter_full_i),
    .filter_error_i(filter_error_i),
    .outstanding_o(outstanding_o), .stall_cnt_o(stall_cnt_o), .error_o(error_o)
  );

  // Reference: in-flight lines in issue order, flush phase (0 run, 1 drain, 2 clear),
  // saturating stall count and sticky error.
  int unsigned m_q[$];
  int m_phase;
  int m_stall;
  bit m_err;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_flight(input int unsigned line);
    foreach (m_q[i]) if (m_q[i] == line) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_stall = 0;
    m_err   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, then advance the model.
  task automatic step(input bit rv, input logic [31:0] addr, input bit rr, input bit rsp,
                      input bit fl, input bit ff, input bit fe, input string tag);
    int unsigned line;
    bit look, run, room, ev, edecr;
    @(negedge clk);
    line = addr >> LO;
    look = in_flight(line);     // exact filter: no false positives
    req_valid_i    = rv;
    req_addr_i     = addr;
    req_ready_i    = rr;
    rsp_valid_i    = rsp;
    flush_i        = fl;
    filter_full_i  = ff;
    filter_error_i = fe;
    look_valid_i   = look;
    #1;
    run   = (m_phase == 0);
    edecr = rsp && (m_q.size() > 0);
    room  = (m_q.size() < MO) || edecr;
    ev    = rv && run && !look && !ff && room;
    check({tag, ".req_valid_o"}, req_valid_o, ev);
    check({tag, ".req_ready_o"}, req_ready_o, rr && run && !look && !ff && room);
    check({tag, ".req_addr_o"}, req_addr_o, addr);
    check({tag, ".look_data_o"}, look_data_o, line);
    check({tag, ".incr_valid_o"}, incr_valid_o, ev && rr);
    if (ev && rr) check({tag, ".incr_data_o"}, incr_data_o, line);
    check({tag, ".decr_valid_o"}, decr_valid_o, edecr);
    if (edecr) check({tag, ".decr_data_o"}, decr_data_o, m_q[0]);
    check({tag, ".filter_clear_o"}, filter_clear_o, m_phase == 2);
    check({tag, ".outstanding_o"}, outstanding_o, m_q.size());
    check({tag, ".stall_cnt_o"}, stall_cnt_o, m_stall);
    check({tag, ".error_o"}, error_o, m_err);
    @(posedge clk);
    if (rv && run && look && m_stall < (1 << SW) - 1) m_stall++;
    m_err = m_err || fe || (rsp && m_q.size() == 0);
    case (m_phase)
      0: if (fl) m_phase = 1;
      1: if (m_q.size() == 0) m_phase = 2;
      default: m_phase = fl ? 1 : 0;
    endcase
    if (edecr) void'(m_q.pop_front());
    if (ev && rr) m_q.push_back(line);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".outstanding_o"}, outstanding_o, 0);
    check({tag, ".stall_cnt_o"}, stall_cnt_o, 0);
    check({tag, ".error_o"}, error_o, 0);
    check({tag, ".filter_clear_o"}, filter_clear_o, 0);
    check({tag, ".incr_valid_o"}, incr_valid_o, 0);
    check({tag, ".decr_valid_o"}, decr_valid_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    {flush_i, req_valid_i, req_ready_i, rsp_valid_i} = '0;
    {look_valid_i, filter_full_i, filter_error_i} = '0;
    req_addr_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    // 1: first issue passes with zero latency
    step(1, 32'h1000, 1, 0, 0, 0, 0, "t1_issue");
    // 2: same line stalls until its response retires it
    for (int i = 0; i < 3; i++) step(1, 32'h1020, 1, 0, 0, 0, 0, "t2_stall");
    step(1, 32'h1020, 1, 1, 0, 0, 0, "t2_rsp");
    step(1, 32'h1020, 1, 0, 0, 0, 0, "t2_reissue");
    step(0, 32'h0, 0, 1, 0, 0, 0, "t2_drain");
    check("t2_stall_total", stall_cnt_o, 4);

    // 3: fill, block at full, issue+response at full, wrap the FIFO
    for (int i = 0; i < MO; i++) step(1, 32'h2000 + i * 32'h40, 1, 0, 0, 0, 0, "t3_fill");
    step(1, 32'h3000, 1, 0, 0, 0, 0, "t3_blocked");
    for (int i = 0; i < 5; i++) step(1, 32'h3000 + i * 32'h40, 1, 1, 0, 0, 0, "t3_swap");
    for (int i = 0; i < MO; i++) step(0, 32'h0, 0, 1, 0, 0, 0, "t3_drain");
    step(1, 32'h5000, 1, 0, 0, 1, 0, "t3_filter_full");

    // 4: stray response raises sticky error
    step(0, 32'h0, 0, 1, 0, 0, 0, "t4_stray");
    step(0, 32'h0, 0, 0, 0, 0, 0, "t4_sticky");
    check("t4_error_sticky", error_o, 1);

    // 5: flush with three in flight, then flush while empty
    for (int i = 0; i < 3; i++) step(1, 32'h6000 + i * 32'h40, 1, 0, 0, 0, 0, "t5_fill");
    step(1, 32'h7000, 1, 0, 1, 0, 0, "t5_flush");
    for (int i = 0; i < 3; i++) step(1, 32'h7000, 1, 1, 1, 0, 0, "t5_rsp");
    for (int i = 0; i < 4; i++) step(1, 32'h7000 + i * 32'h40, 1, 0, 0, 0, 0, "t5_after");
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 1, 0, 0, 0, "t5_drain");
    step(0, 32'h0, 0, 0, 1, 0, 0, "t5_flush_empty");
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 0, 0, 0, "t5_clear");

    // 6: asynchronous reset in the middle of a drain
    step(1, 32'h8000, 1, 0, 0, 0, 0, "t6_fill");
    step(1, 32'h8040, 1, 0, 0, 0, 0, "t6_fill");
    step(0, 32'h0, 0, 0, 1, 0, 0, "t6_flush");
    step(0, 32'h0, 0, 0, 1, 0, 0, "t6_drain");
    @(negedge clk);
    #2;
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
    flush_i     = 1'b0;
    rst_ni      = 1'b0;
    #1;
    check_reset_outputs("t6_async_reset");
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;

    // Random traffic over a few lines so conflicts, saturation and flushes all occur
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7,
           32'h8000 + $urandom_range(0, 5) * 32'h40 + $urandom_range(0, 63),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 199) < 1,
           "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
